// File: rtl/posit_encoder.sv
// Posit multiplier stage 5: packs sign/scale/fraction into an N-bit posit with saturation and negation.
// Define POSIT_ENCODER_RNE_EN for round-to-nearest-even; otherwise the ROUND stage truncates.
module posit_encoder #(
    parameter int N       = 16,
    parameter int ES      = 1,
    parameter int FRAC_W  = 16,
    parameter int SCALE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               encoder_start,
    input  logic               is_zero,
    input  logic               is_nar,
    input  logic               sign_in,
    input  logic [SCALE_W-1:0] scale_in,
    input  logic [FRAC_W-1:0]  frac_in,
    input  logic               sticky_in,
    output logic [N-1:0]       posit_out,
    output logic               encode_done,
    output logic               busy,
    output logic               start_overrun
);

    localparam int BW = ES + FRAC_W;
    localparam int LW = BW + N - 1;

    typedef enum logic [1:0] {IDLE, SPECIAL, PACK, ROUND} state_t;

    state_t                     state_q, state_d;
    logic                       sign_q;
    logic signed [SCALE_W-1:0]  scale_q;
    logic [FRAC_W-1:0]          frac_q;
    logic                       stin_q;
    logic [N-2:0]               mag_q, mag_d;
    logic                       guard_q, guard_d;
    logic                       sticky_q, sticky_d;
    logic [N-1:0]               posit_q, posit_d;
    logic                       done_q;
    logic                       overrun_q;

    logic [BW-1:0]              body_s;
    logic signed [SCALE_W-1:0]  k_s;
    int                         k_int;
    int                         rlen;
    logic [LW-1:0]              str_s;
    logic                       inc_s;
    logic [N-1:0]               sum_s;
    logic [N-1:0]               rmag_s;

    generate
        if (ES > 0) begin : g_exp
            assign body_s = {scale_q[ES-1:0], frac_q};
        end else begin : g_noexp
            assign body_s = frac_q;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; specials finish in one cycle, normal encodes walk PACK then ROUND
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (encoder_start) begin
                    state_d = (is_nar | is_zero) ? SPECIAL : PACK;
                end else begin
                    state_d = IDLE;
                end
            end
            SPECIAL: state_d = IDLE;
            PACK:    state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q != IDLE);
    end

    // PACK: regime/exponent/fraction string, split into kept magnitude, guard and sticky
    always_comb begin
        k_s      = scale_q >>> ES;
        k_int    = int'(k_s);
        rlen     = 0;
        str_s    = '0;
        mag_d    = '0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        if (k_int >= N - 2) begin
            mag_d = {(N-1){1'b1}};
        end else if (k_int <= -(N - 1)) begin
            mag_d = {{(N-2){1'b0}}, 1'b1};
        end else begin
            if (k_int >= 0) begin
                rlen  = k_int + 2;
                str_s = ({body_s, {(N-1){1'b0}}} >> rlen) | ~({LW{1'b1}} >> (k_int + 1));
            end else begin
                rlen  = 1 - k_int;
                str_s = ({body_s, {(N-1){1'b0}}} >> rlen) | ({{(LW-1){1'b0}}, 1'b1} << (LW - rlen));
            end
            mag_d    = str_s[LW-1 -: N-1];
            guard_d  = str_s[LW-N];
            sticky_d = (|str_s[LW-N-1:0]) | stin_q;
        end
    end

    // ROUND: optional RNE increment, clamp a carry-out back to maxpos, then apply sign
    always_comb begin
`ifdef POSIT_ENCODER_RNE_EN
        inc_s = guard_q & (sticky_q | mag_q[0]);
`else
        inc_s = 1'b0;
`endif
        sum_s = {1'b0, mag_q} + {{(N-1){1'b0}}, inc_s};
        if (sum_s[N-1]) begin
            rmag_s = {1'b0, {(N-1){1'b1}}};
        end else begin
            rmag_s = sum_s;
        end
        if (sign_q) begin
            posit_d = ~rmag_s + {{(N-1){1'b0}}, 1'b1};
        end else begin
            posit_d = rmag_s;
        end
    end

`ifndef POSIT_ENCODER_RNE_EN
    logic unused_round_s;
    assign unused_round_s = guard_q ^ sticky_q;
`endif

    // Datapath registers: input capture, pack results, output word and handshake pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q    <= 1'b0;
            scale_q   <= '0;
            frac_q    <= '0;
            stin_q    <= 1'b0;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            posit_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= encoder_start & (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (encoder_start) begin
                        sign_q  <= sign_in;
                        scale_q <= scale_in;
                        frac_q  <= frac_in;
                        stin_q  <= sticky_in;
                        if (is_nar | is_zero) begin
                            posit_q <= is_nar ? {1'b1, {(N-1){1'b0}}} : {N{1'b0}};
                            done_q  <= 1'b1;
                        end else begin
                            posit_q <= posit_q;
                        end
                    end else begin
                        posit_q <= posit_q;
                    end
                end
                PACK: begin
                    mag_q    <= mag_d;
                    guard_q  <= guard_d;
                    sticky_q <= sticky_d;
                end
                ROUND: begin
                    posit_q <= posit_d;
                    done_q  <= 1'b1;
                end
                default: begin
                    posit_q <= posit_q;
                end
            endcase
        end
    end

    assign posit_out     = posit_q;
    assign encode_done   = done_q;
    assign start_overrun = overrun_q;

endmodule
